rocc_cmd_decoupler: RTL and testbench
=====================================

# rocc_cmd_decoupler

Two-way elastic buffer between the core's RoCC port and a RoCC accelerator. Commands are queued toward the accelerator, responses queued back to the core. A response-credit scheme guarantees that every response the accelerator is allowed to produce is accepted the cycle it is presented, so accelerators that pulse `resp_valid` without waiting for `resp_ready` never lose data. The block also generates `core_busy` for the core's fence/interlock logic.

## Interface
- xLen, 64, width of rs1/rs2/response data
- CMD_DEPTH, 4, command FIFO entries; power of two, >= 2
- RESP_DEPTH, 2, response FIFO entries and credit pool; power of two, >= 1
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- core_cmd_ready  out  1  command FIFO not full
- core_cmd_valid  in  1  core presents a command
- core_cmd_bits_inst_funct / _opcode  in  7 each  instruction fields
- core_cmd_bits_inst_rs1 / _rs2 / _rd  in  5 each  register indices
- core_cmd_bits_inst_xd / _xs1 / _xs2  in  1 each  operand/result flags
- core_cmd_bits_rs1 / _rs2  in  xLen each  operand values
- acc_cmd_*  out (valid and bits) / acc_cmd_ready in  same fields and widths as core_cmd_*, accelerator side
- acc_resp_ready  out  1  response FIFO not full
- acc_resp_valid  in  1
- acc_resp_bits_rd  in  5
- acc_resp_bits_data  in  xLen
- core_resp_ready  in  1
- core_resp_valid  out  1
- core_resp_bits_rd  out  5
- core_resp_bits_data  out  xLen
- acc_busy  in  1  accelerator-internal busy
- core_busy  out  1  aggregate busy
- resp_err  out  1  sticky: unsolicited response seen

## Operation
- Command FIFO, CMD_DEPTH entries, stores all command fields.
  - Enqueue on core_cmd_valid && core_cmd_ready.
  - Dequeue on acc_cmd_valid && acc_cmd_ready.
  - core_cmd_ready = !cmd_full. A dequeue in the same cycle does not make a full FIFO ready.
- Response FIFO, RESP_DEPTH entries, stores rd and data.
  - Enqueue on acc_resp_valid && acc_resp_ready.
  - Dequeue on core_resp_valid && core_resp_ready.
  - acc_resp_ready = !resp_full.
- Outstanding counter `outst`, width clog2(RESP_DEPTH+1).
  - +1 on dequeue of a command with xd=1.
  - -1 on response enqueue; saturates at 0.
  - Simultaneous +1 and -1 leaves it unchanged.
- Credits = RESP_DEPTH - resp_count - outst.
  - acc_cmd_valid = !cmd_empty && (!head.xd || credits > 0).
  - Commands with xd=0 are never credit-gated.
  - A blocked xd=1 head also blocks the commands behind it: strict in-order.
- A response enqueued while outst==0 is stored normally and sets resp_err. resp_err clears only on reset.
- core_busy = !cmd_empty || outst != 0 || !resp_empty || acc_busy (combinational).

## Timing
- No bypass paths; both FIFOs are registered.
  - Command accepted at cycle N → earliest acc_cmd_valid at N+1.
  - Response accepted at cycle N → earliest core_resp_valid at N+1.
- Full throughput: one enqueue and one dequeue per cycle in each direction when neither full nor empty.
- Pointers wrap modulo depth. The full/empty distinction uses an extra pointer bit or a count.
- While reset is asserted, and in the cycle after it deasserts (state is cleared on that edge):
  - core_cmd_ready=1, acc_resp_ready=1 (FIFOs empty).
  - acc_cmd_valid=0, core_resp_valid=0.
  - core_busy = acc_busy.
  - resp_err=0.
  - Bits outputs are don't-care while their valid is 0. Storage arrays are not reset.
- Reset mid-operation: all queued commands and responses are discarded and outst←0 on the reset edge. No valid is asserted in the reset cycle.
- Valid outputs are stable until their handshake completes. Bits do not change while valid=1 and ready=0.

## Test plan
- Single accumulate: 1 cycle after reset, send xd=1, rd=5, rs1=3, rs2=4 to an accumulator model.
  - acc_cmd_valid rises the next cycle.
  - core_resp shows rd=5, data=7.
  - core_busy falls 1 cycle after the response is taken.
- Credit stall: RESP_DEPTH=2, core_resp_ready=0, three xd=1 commands.
  - Two commands issue.
  - The third holds acc_cmd_valid=0 until core_resp_ready=1 drains one response; it then issues the cycle after.
  - No response is dropped.
- Command full: acc_cmd_ready=0, push five xd=0 commands.
  - core_cmd_ready=0 after the fourth.
  - The fifth is held.
  - Release → commands emerge in order, one per cycle.
- Mixed order: xd=0 commands interleave freely behind credit availability.
  - Sequence xd=1, xd=0, xd=1 with zero credits at the second xd=1: the first two issue, the third waits.
- Unsolicited response with outst=0 and data=0xAB: resp_err=1 and stays set; the response is delivered to the core.
- Reset during traffic: reset with 3 commands and 1 response queued.
  - Next cycle: all valids 0, outst=0, core_busy=acc_busy.
  - Subsequent traffic behaves as after power-on.

Source files
------------

// File: rtl/rocc_cmd_decoupler_if.sv
// rocc_cmd_decoupler_if: one RoCC port (command, response, busy).
// master issues commands and takes responses; slave does the reverse.
interface rocc_cmd_decoupler_if #(
    parameter int xLen = 64
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [6:0]      cmd_bits_inst_funct;
    logic [4:0]      cmd_bits_inst_rs2;
    logic [4:0]      cmd_bits_inst_rs1;
    logic            cmd_bits_inst_xd;
    logic            cmd_bits_inst_xs1;
    logic            cmd_bits_inst_xs2;
    logic [4:0]      cmd_bits_inst_rd;
    logic [6:0]      cmd_bits_inst_opcode;
    logic [xLen-1:0] cmd_bits_rs1;
    logic [xLen-1:0] cmd_bits_rs2;
    logic            resp_valid;
    logic            resp_ready;
    logic [4:0]      resp_bits_rd;
    logic [xLen-1:0] resp_bits_data;
    logic            busy;

    modport master (
        output cmd_valid, cmd_bits_inst_funct, cmd_bits_inst_rs2,
               cmd_bits_inst_rs1, cmd_bits_inst_xd, cmd_bits_inst_xs1,
               cmd_bits_inst_xs2, cmd_bits_inst_rd, cmd_bits_inst_opcode,
               cmd_bits_rs1, cmd_bits_rs2, resp_ready,
        input  cmd_ready, resp_valid, resp_bits_rd, resp_bits_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_bits_inst_funct, cmd_bits_inst_rs2,
               cmd_bits_inst_rs1, cmd_bits_inst_xd, cmd_bits_inst_xs1,
               cmd_bits_inst_xs2, cmd_bits_inst_rd, cmd_bits_inst_opcode,
               cmd_bits_rs1, cmd_bits_rs2, resp_ready,
        output cmd_ready, resp_valid, resp_bits_rd, resp_bits_data, busy
    );
endinterface

// File: rtl/rocc_cmd_decoupler.sv
// rocc_cmd_decoupler: command/response FIFOs between core and accelerator.
// Response credits keep the response FIFO able to absorb every reply.
module rocc_cmd_decoupler #(
    parameter int xLen       = 64,
    parameter int CMD_DEPTH  = 4,
    parameter int RESP_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    rocc_cmd_decoupler_if.slave  core,
    rocc_cmd_decoupler_if.master acc,
    output logic                 resp_err
);
    localparam int CAW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CCW = $clog2(CMD_DEPTH + 1);
    localparam int RAW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int RCW = $clog2(RESP_DEPTH + 1);
    localparam logic [CAW-1:0] C_LAST = CAW'(CMD_DEPTH - 1);
    localparam logic [CCW-1:0] C_FULL = CCW'(CMD_DEPTH);
    localparam logic [RAW-1:0] R_LAST = RAW'(RESP_DEPTH - 1);
    localparam logic [RCW-1:0] R_FULL = RCW'(RESP_DEPTH);

    typedef struct packed {
        logic [6:0]      funct;
        logic [4:0]      rs2;
        logic [4:0]      rs1;
        logic            xd;
        logic            xs1;
        logic            xs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [xLen-1:0] d1;
        logic [xLen-1:0] d2;
    } cmd_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [xLen-1:0] data;
    } resp_t;

    cmd_t           cmd_mem [CMD_DEPTH];
    cmd_t           cmd_in;
    cmd_t           cmd_head;
    logic [CAW-1:0] cmd_wr;
    logic [CAW-1:0] cmd_rd;
    logic [CCW-1:0] cmd_count;
    logic           cmd_enq;
    logic           cmd_deq;

    resp_t          resp_mem [RESP_DEPTH];
    resp_t          resp_in;
    resp_t          resp_head;
    logic [RAW-1:0] resp_wr;
    logic [RAW-1:0] resp_rd;
    logic [RCW-1:0] resp_count;
    logic           resp_enq;
    logic           resp_deq;

    logic [RCW-1:0] outst;
    logic [RCW:0]   used;
    logic           credit_ok;
    logic           outst_inc;
    logic           outst_dec;
    logic           err_q;

    assign cmd_in.funct  = core.cmd_bits_inst_funct;
    assign cmd_in.rs2    = core.cmd_bits_inst_rs2;
    assign cmd_in.rs1    = core.cmd_bits_inst_rs1;
    assign cmd_in.xd     = core.cmd_bits_inst_xd;
    assign cmd_in.xs1    = core.cmd_bits_inst_xs1;
    assign cmd_in.xs2    = core.cmd_bits_inst_xs2;
    assign cmd_in.rd     = core.cmd_bits_inst_rd;
    assign cmd_in.opcode = core.cmd_bits_inst_opcode;
    assign cmd_in.d1     = core.cmd_bits_rs1;
    assign cmd_in.d2     = core.cmd_bits_rs2;
    assign cmd_head      = cmd_mem[cmd_rd];

    // Replies already queued plus replies still owed use up credits.
    assign used      = {1'b0, resp_count} + {1'b0, outst};
    assign credit_ok = used < {1'b0, R_FULL};

    assign core.cmd_ready = reset || (cmd_count != C_FULL);
    assign acc.cmd_valid  = !reset && (cmd_count != '0)
                            && (!cmd_head.xd || credit_ok);
    assign cmd_enq = core.cmd_valid && core.cmd_ready;
    assign cmd_deq = acc.cmd_valid && acc.cmd_ready;

    assign acc.cmd_bits_inst_funct  = cmd_head.funct;
    assign acc.cmd_bits_inst_rs2    = cmd_head.rs2;
    assign acc.cmd_bits_inst_rs1    = cmd_head.rs1;
    assign acc.cmd_bits_inst_xd     = cmd_head.xd;
    assign acc.cmd_bits_inst_xs1    = cmd_head.xs1;
    assign acc.cmd_bits_inst_xs2    = cmd_head.xs2;
    assign acc.cmd_bits_inst_rd     = cmd_head.rd;
    assign acc.cmd_bits_inst_opcode = cmd_head.opcode;
    assign acc.cmd_bits_rs1         = cmd_head.d1;
    assign acc.cmd_bits_rs2         = cmd_head.d2;

    assign resp_in.rd   = acc.resp_bits_rd;
    assign resp_in.data = acc.resp_bits_data;
    assign resp_head    = resp_mem[resp_rd];

    assign acc.resp_ready      = reset || (resp_count != R_FULL);
    assign core.resp_valid     = !reset && (resp_count != '0);
    assign core.resp_bits_rd   = resp_head.rd;
    assign core.resp_bits_data = resp_head.data;
    assign resp_enq = acc.resp_valid && acc.resp_ready;
    assign resp_deq = core.resp_valid && core.resp_ready;

    assign outst_inc = cmd_deq && cmd_head.xd;
    assign outst_dec = resp_enq && (outst != '0);

    assign core.busy = acc.busy || (!reset && ((cmd_count != '0)
                       || (outst != '0) || (resp_count != '0)));
    assign resp_err  = err_q && !reset;

    // Command storage is written on enqueue only and never cleared.
    always_ff @(posedge clock) begin
        if (cmd_enq) begin
            cmd_mem[cmd_wr] <= cmd_in;
        end
    end

    // Command FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_wr    <= '0;
            cmd_rd    <= '0;
            cmd_count <= '0;
        end else begin
            if (cmd_enq) begin
                cmd_wr <= (cmd_wr == C_LAST) ? '0 : cmd_wr + 1'b1;
            end
            if (cmd_deq) begin
                cmd_rd <= (cmd_rd == C_LAST) ? '0 : cmd_rd + 1'b1;
            end
            if (cmd_enq && !cmd_deq) begin
                cmd_count <= cmd_count + 1'b1;
            end else if (cmd_deq && !cmd_enq) begin
                cmd_count <= cmd_count - 1'b1;
            end
        end
    end

    // Response storage is written on enqueue only and never cleared.
    always_ff @(posedge clock) begin
        if (resp_enq) begin
            resp_mem[resp_wr] <= resp_in;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_wr    <= '0;
            resp_rd    <= '0;
            resp_count <= '0;
        end else begin
            if (resp_enq) begin
                resp_wr <= (resp_wr == R_LAST) ? '0 : resp_wr + 1'b1;
            end
            if (resp_deq) begin
                resp_rd <= (resp_rd == R_LAST) ? '0 : resp_rd + 1'b1;
            end
            if (resp_enq && !resp_deq) begin
                resp_count <= resp_count + 1'b1;
            end else if (resp_deq && !resp_enq) begin
                resp_count <= resp_count - 1'b1;
            end
        end
    end

    // Owed replies; a reply arriving with none owed flags an error.
    always_ff @(posedge clock) begin
        if (reset) begin
            outst <= '0;
            err_q <= 1'b0;
        end else begin
            if (outst_inc && !outst_dec) begin
                outst <= outst + 1'b1;
            end else if (outst_dec && !outst_inc) begin
                outst <= outst - 1'b1;
            end
            if (resp_enq && (outst == '0)) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rocc_cmd_decoupler.sv
// tb_rocc_cmd_decoupler: random and directed traffic with a queue-based
// reference model, an accumulator accelerator model and a scoreboard.
module tb_rocc_cmd_decoupler;
    localparam int XL = 64;
    localparam int CD = 4;
    localparam int RD = 2;

    typedef struct packed {
        logic [6:0]    funct;
        logic [4:0]    rs2;
        logic [4:0]    rs1;
        logic          xd;
        logic          xs1;
        logic          xs2;
        logic [4:0]    rd;
        logic [6:0]    opcode;
        logic [XL-1:0] d1;
        logic [XL-1:0] d2;
    } cmd_t;

    typedef struct packed {
        logic [4:0]    rd;
        logic [XL-1:0] data;
    } rsp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic resp_err;

    int checks = 0;
    int failures = 0;

    rocc_cmd_decoupler_if #(.xLen(XL)) core_if ();
    rocc_cmd_decoupler_if #(.xLen(XL)) acc_if ();

    rocc_cmd_decoupler #(
        .xLen(XL),
        .CMD_DEPTH(CD),
        .RESP_DEPTH(RD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .core(core_if),
        .acc(acc_if),
        .resp_err(resp_err)
    );

    always #5 clock = ~clock;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    rsp_t pend_q[$];
    int   n_outst = 0;
    logic err_m = 1'b0;
    int   p_ardy = 0;
    int   p_crdy = 0;
    int   p_resp = 0;
    int   p_busy = 0;
    int   man_cnt = 0;
    rsp_t man_rsp;
    int   n_acc_cmd = 0;
    int   n_core_rsp = 0;
    rsp_t last_rsp;

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0b exp=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [159:0] act,
                        input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t core_cmd();
        cmd_t c;
        c.funct  = core_if.cmd_bits_inst_funct;
        c.rs2    = core_if.cmd_bits_inst_rs2;
        c.rs1    = core_if.cmd_bits_inst_rs1;
        c.xd     = core_if.cmd_bits_inst_xd;
        c.xs1    = core_if.cmd_bits_inst_xs1;
        c.xs2    = core_if.cmd_bits_inst_xs2;
        c.rd     = core_if.cmd_bits_inst_rd;
        c.opcode = core_if.cmd_bits_inst_opcode;
        c.d1     = core_if.cmd_bits_rs1;
        c.d2     = core_if.cmd_bits_rs2;
        return c;
    endfunction

    function automatic cmd_t acc_cmd();
        cmd_t c;
        c.funct  = acc_if.cmd_bits_inst_funct;
        c.rs2    = acc_if.cmd_bits_inst_rs2;
        c.rs1    = acc_if.cmd_bits_inst_rs1;
        c.xd     = acc_if.cmd_bits_inst_xd;
        c.xs1    = acc_if.cmd_bits_inst_xs1;
        c.xs2    = acc_if.cmd_bits_inst_xs2;
        c.rd     = acc_if.cmd_bits_inst_rd;
        c.opcode = acc_if.cmd_bits_inst_opcode;
        c.d1     = acc_if.cmd_bits_rs1;
        c.d2     = acc_if.cmd_bits_rs2;
        return c;
    endfunction

    function automatic cmd_t mk(input logic xd, input logic [4:0] rd,
                                input logic [XL-1:0] a,
                                input logic [XL-1:0] b);
        cmd_t c;
        c.funct  = 7'($urandom);
        c.rs2    = 5'($urandom);
        c.rs1    = 5'($urandom);
        c.xd     = xd;
        c.xs1    = 1'($urandom);
        c.xs2    = 1'($urandom);
        c.rd     = rd;
        c.opcode = 7'($urandom);
        c.d1     = a;
        c.d2     = b;
        return c;
    endfunction

    task automatic drive(input logic v, input cmd_t c);
        core_if.cmd_valid            = v;
        core_if.cmd_bits_inst_funct  = c.funct;
        core_if.cmd_bits_inst_rs2    = c.rs2;
        core_if.cmd_bits_inst_rs1    = c.rs1;
        core_if.cmd_bits_inst_xd     = c.xd;
        core_if.cmd_bits_inst_xs1    = c.xs1;
        core_if.cmd_bits_inst_xs2    = c.xs2;
        core_if.cmd_bits_inst_rd     = c.rd;
        core_if.cmd_bits_inst_opcode = c.opcode;
        core_if.cmd_bits_rs1         = c.d1;
        core_if.cmd_bits_rs2         = c.d2;
    endtask

    task automatic idle(input int n);
        core_if.cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input cmd_t c);
        int w;
        w = 0;
        drive(1'b1, c);
        @(negedge clock);
        while (!core_if.cmd_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        chkb("send_accept", core_if.cmd_ready, 1'b1);
        @(posedge clock);
        #1;
    endtask

    // Monitor/scoreboard at negedge, accelerator model drives after posedge.
    initial begin : mon
        cmd_t c;
        cmd_t e;
        rsp_t r;
        rsp_t er;
        logic exp_av;
        int   man_done;
        man_done = 0;
        acc_if.cmd_ready      = 1'b0;
        acc_if.resp_valid     = 1'b0;
        acc_if.resp_bits_rd   = '0;
        acc_if.resp_bits_data = '0;
        acc_if.busy           = 1'b0;
        core_if.resp_ready    = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                chkb("rst_cmd_ready", core_if.cmd_ready, 1'b1);
                chkb("rst_resp_ready", acc_if.resp_ready, 1'b1);
                chkb("rst_acc_valid", acc_if.cmd_valid, 1'b0);
                chkb("rst_core_valid", core_if.resp_valid, 1'b0);
                chkb("rst_busy", core_if.busy, acc_if.busy);
                chkb("rst_err", resp_err, 1'b0);
                cmd_q.delete();
                rsp_q.delete();
                pend_q.delete();
                n_outst = 0;
                err_m   = 1'b0;
            end else begin
                exp_av = (cmd_q.size() != 0) && (!cmd_q[0].xd ||
                         (n_outst + rsp_q.size()) < RD);
                chkb("core_cmd_ready", core_if.cmd_ready, cmd_q.size() < CD);
                chkb("acc_cmd_valid", acc_if.cmd_valid, exp_av);
                chkb("acc_resp_ready", acc_if.resp_ready, rsp_q.size() < RD);
                chkb("core_resp_valid", core_if.resp_valid, rsp_q.size() != 0);
                chkb("core_busy", core_if.busy, (cmd_q.size() != 0) ||
                     (n_outst != 0) || (rsp_q.size() != 0) || acc_if.busy);
                chkb("resp_err", resp_err, err_m);
                if (acc_if.resp_valid) begin
                    chkb("resp_no_drop", acc_if.resp_ready, 1'b1);
                    if (acc_if.resp_ready) begin
                        if (n_outst == 0) err_m = 1'b1;
                        else n_outst--;
                        r.rd   = acc_if.resp_bits_rd;
                        r.data = acc_if.resp_bits_data;
                        rsp_q.push_back(r);
                    end
                end
                if (acc_if.cmd_valid && acc_if.cmd_ready && cmd_q.size() != 0) begin
                    c = acc_cmd();
                    e = cmd_q.pop_front();
                    chkv("acc_cmd_bits", 160'(c), 160'(e));
                    n_acc_cmd++;
                    if (e.xd) begin
                        n_outst++;
                        er.rd   = e.rd;
                        er.data = e.d1 + e.d2;
                        pend_q.push_back(er);
                    end
                end
                if (core_if.cmd_valid && core_if.cmd_ready) begin
                    cmd_q.push_back(core_cmd());
                end
                if (core_if.resp_valid && core_if.resp_ready && rsp_q.size() > 1) begin
                    r.rd   = core_if.resp_bits_rd;
                    r.data = core_if.resp_bits_data;
                    er = rsp_q.pop_front();
                    chkv("core_resp", 160'(r), 160'(er));
                    last_rsp = r;
                    n_core_rsp++;
                end else if (core_if.resp_valid && core_if.resp_ready) begin
                    r.rd   = core_if.resp_bits_rd;
                    r.data = core_if.resp_bits_data;
                    if (rsp_q.size() != 0) begin
                        er = rsp_q.pop_front();
                        chkv("core_resp", 160'(r), 160'(er));
                    end
                    last_rsp = r;
                    n_core_rsp++;
                end
            end
            @(posedge clock);
            #1;
            acc_if.cmd_ready   = ($urandom_range(99) < p_ardy);
            core_if.resp_ready = ($urandom_range(99) < p_crdy);
            acc_if.busy        = ($urandom_range(99) < p_busy);
            if (man_done != man_cnt) begin
                man_done++;
                acc_if.resp_valid     = 1'b1;
                acc_if.resp_bits_rd   = man_rsp.rd;
                acc_if.resp_bits_data = man_rsp.data;
            end else if (pend_q.size() != 0 && $urandom_range(99) < p_resp) begin
                r = pend_q.pop_front();
                acc_if.resp_valid     = 1'b1;
                acc_if.resp_bits_rd   = r.rd;
                acc_if.resp_bits_data = r.data;
            end else begin
                acc_if.resp_valid = 1'b0;
            end
        end
    end

    initial begin : stim
        int   base;
        int   rbase;
        cmd_t c5;
        drive(1'b0, '0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chkb("init_cmd_ready", core_if.cmd_ready, 1'b1);
        chkb("init_acc_valid", acc_if.cmd_valid, 1'b0);
        chkb("init_core_valid", core_if.resp_valid, 1'b0);
        chkb("init_err", resp_err, 1'b0);

        p_ardy = 100;
        p_crdy = 100;
        p_resp = 100;
        p_busy = 0;
        idle(1);
        rbase = n_core_rsp;
        send(mk(1'b1, 5'd5, 64'd3, 64'd4));
        idle(8);
        chki("acc1_count", n_core_rsp - rbase, 1);
        chkv("acc1_rsp", 160'(last_rsp), 160'({5'd5, 64'd7}));
        chkb("acc1_idle", core_if.busy, 1'b0);

        p_crdy = 0;
        idle(2);
        base  = n_acc_cmd;
        rbase = n_core_rsp;
        for (int i = 0; i < 3; i++) begin
            send(mk(1'b1, 5'(i + 1), 64'($urandom), 64'($urandom)));
        end
        idle(8);
        chki("stall_issued", n_acc_cmd - base, 2);
        p_crdy = 100;
        idle(12);
        chki("stall_released", n_acc_cmd - base, 3);
        chki("stall_resps", n_core_rsp - rbase, 3);

        p_ardy = 0;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            send(mk(1'b0, 5'(i), 64'(i), 64'($urandom)));
        end
        c5 = mk(1'b0, 5'd4, 64'd4, 64'd0);
        drive(1'b1, c5);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chkb("cmd_full", core_if.cmd_ready, 1'b0);
        p_ardy = 100;
        send(c5);
        idle(10);

        p_crdy = 0;
        idle(2);
        base = n_acc_cmd;
        send(mk(1'b1, 5'd10, 64'd1, 64'd1));
        send(mk(1'b1, 5'd11, 64'd2, 64'd2));
        send(mk(1'b0, 5'd12, 64'd3, 64'd3));
        send(mk(1'b1, 5'd13, 64'd4, 64'd4));
        idle(8);
        chki("mixed_issued", n_acc_cmd - base, 3);
        p_crdy = 100;
        idle(12);
        chki("mixed_drained", n_acc_cmd - base, 4);

        man_rsp.rd   = 5'd1;
        man_rsp.data = 64'hAB;
        man_cnt++;
        idle(6);
        chkb("resp_err_set", resp_err, 1'b1);
        chkv("unsol_data", 160'(last_rsp.data), 160'(64'hAB));
        idle(10);
        chkb("resp_err_sticky", resp_err, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                p_ardy = $urandom_range(100);
                p_crdy = $urandom_range(100);
                p_resp = $urandom_range(100, 20);
                p_busy = $urandom_range(30);
            end
            if (i == 1500) begin
                drive(1'b0, '0);
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
            end
            drive($urandom_range(99) < 60,
                  mk(1'($urandom), 5'($urandom), {$urandom, $urandom},
                     {$urandom, $urandom}));
            @(posedge clock);
            #1;
        end
        p_ardy = 100;
        p_crdy = 100;
        p_resp = 100;
        p_busy = 0;
        idle(40);
        chkb("drain_idle", core_if.busy, 1'b0);

        p_crdy = 0;
        idle(2);
        send(mk(1'b1, 5'd7, 64'd1, 64'd2));
        idle(6);
        p_ardy = 0;
        idle(2);
        for (int i = 0; i < 3; i++) begin
            send(mk(1'b0, 5'(i), 64'(i), 64'(i)));
        end
        chkb("pre_rst_resp", core_if.resp_valid, 1'b1);
        p_busy = 50;
        drive(1'b0, '0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chkb("post_rst_acc_valid", acc_if.cmd_valid, 1'b0);
        chkb("post_rst_core_valid", core_if.resp_valid, 1'b0);
        chkb("post_rst_busy", core_if.busy, acc_if.busy);
        chkb("post_rst_err", resp_err, 1'b0);

        p_ardy = 100;
        p_crdy = 100;
        p_busy = 0;
        idle(2);
        rbase = n_core_rsp;
        send(mk(1'b1, 5'd9, 64'd100, 64'd23));
        idle(8);
        chki("acc2_count", n_core_rsp - rbase, 1);
        chkv("acc2_rsp", 160'(last_rsp), 160'({5'd9, 64'd123}));
        chkb("acc2_idle", core_if.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
